// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// PS/2 host-to-device transmitter. Sends one command byte to the attached
// keyboard or mouse using the full host request sequence: the clock line is
// inhibited, request-to-send is signalled with a start bit, the device clocks
// out d0..d7, odd parity and stop, and the device ACK bit is checked.
// Both PS/2 lines are open-collector; this block only produces drive-low
// enables and the top level builds the pads from them.
//
// Ports
//   clk          system clock (100 MHz nominal)
//   reset        asynchronous active-high reset
//   tx_data      command byte, latched when tx_start is accepted
//   tx_start     one-cycle request, only accepted while idle
//   ps2_clk_in   raw PS/2 clock pad level
//   ps2_data_in  raw PS/2 data pad level
//   ps2_clk_oe   1 pulls the PS/2 clock line low
//   ps2_data_oe  1 pulls the PS/2 data line low
//   busy         high whenever a transfer is in progress
//   tx_done      one-cycle pulse: frame sent and ACKed
//   tx_error     one-cycle pulse: missing ACK or device timeout
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] INHIBIT_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    // -----------------------------------------------------------------------
    // Pad synchronizers. The clock line gets a third stage so a falling edge
    // can be seen as s3=1, s2=0. Both chains reset to 1 (idle bus) so that
    // leaving reset never looks like a device clock edge.
    // -----------------------------------------------------------------------
    logic [2:0] clk_sync_reg;
    logic [1:0] data_sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_reg  <= 3'b111;
            data_sync_reg <= 2'b11;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[1:0], ps2_clk_in};
            data_sync_reg <= {data_sync_reg[0], ps2_data_in};
        end
    end

    logic clk_s2;
    logic data_s2;
    logic clk_fall;

    assign clk_s2   = clk_sync_reg[1];
    assign data_s2  = data_sync_reg[1];
    assign clk_fall = clk_sync_reg[2] & ~clk_sync_reg[1];

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t          state_reg,       state_next;
    logic [9:0]      shift_reg,       shift_next;
    logic [3:0]      bit_cnt_reg,     bit_cnt_next;
    logic [IW-1:0]   inhibit_cnt_reg, inhibit_cnt_next;
    logic [TW-1:0]   timeout_cnt_reg, timeout_cnt_next;
    logic            clk_oe_reg,      clk_oe_next;
    logic            data_oe_reg,     data_oe_next;
    logic            busy_reg,        busy_next;
    logic            done_reg,        done_next;
    logic            error_reg,       error_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            inhibit_cnt_reg <= '0;
            timeout_cnt_reg <= '0;
            clk_oe_reg      <= 1'b0;
            data_oe_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            bit_cnt_reg     <= bit_cnt_next;
            inhibit_cnt_reg <= inhibit_cnt_next;
            timeout_cnt_reg <= timeout_cnt_next;
            clk_oe_reg      <= clk_oe_next;
            data_oe_reg     <= data_oe_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            error_reg       <= error_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. The *_next outputs describe the line drive for the
    // state being entered, so every output is a plain register.
    // -----------------------------------------------------------------------
    logic device_phase;

    always_comb begin
        state_next       = state_reg;
        shift_next       = shift_reg;
        bit_cnt_next     = bit_cnt_reg;
        inhibit_cnt_next = inhibit_cnt_reg;
        timeout_cnt_next = timeout_cnt_reg;
        clk_oe_next      = 1'b0;
        data_oe_next     = data_oe_reg;
        done_next        = 1'b0;
        error_next       = 1'b0;
        device_phase     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                data_oe_next = 1'b0;
                if (tx_start) begin
                    // Frame order on the wire after the start bit:
                    // d0..d7, odd parity, stop.
                    shift_next       = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_next     = '0;
                    inhibit_cnt_next = '0;
                    timeout_cnt_next = '0;
                    clk_oe_next      = 1'b1;
                    state_next       = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                clk_oe_next  = 1'b1;
                data_oe_next = 1'b0;
                if (inhibit_cnt_reg == INHIBIT_LAST) begin
                    data_oe_next = 1'b1;
                    state_next   = S_RTS;
                end else begin
                    inhibit_cnt_next = inhibit_cnt_reg + IW'(1);
                end
            end

            S_RTS: begin
                // Release the clock while still holding the start bit.
                data_oe_next = 1'b1;
                state_next   = S_SEND;
            end

            S_SEND: begin
                device_phase = 1'b1;
                if (clk_fall) begin
                    data_oe_next = ~shift_reg[0];
                    shift_next   = {1'b0, shift_reg[9:1]};
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd9) begin
                        state_next = S_ACK;
                    end
                end
            end

            S_ACK: begin
                device_phase = 1'b1;
                data_oe_next = 1'b0;
                if (clk_fall) begin
                    if (!data_s2) begin
                        state_next = S_WAIT_IDLE;
                    end else begin
                        state_next = S_IDLE;
                        error_next = 1'b1;
                    end
                end
            end

            S_WAIT_IDLE: begin
                device_phase = 1'b1;
                data_oe_next = 1'b0;
                if (clk_s2 && data_s2) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end

            default: begin
                state_next   = S_IDLE;
                data_oe_next = 1'b0;
            end
        endcase

        // Device watchdog: overrides whatever the state decided, including a
        // fall or bus-idle seen in the same cycle.
        if (device_phase) begin
            if (timeout_cnt_reg == TIMEOUT_LAST) begin
                state_next   = S_IDLE;
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b0;
                done_next    = 1'b0;
                error_next   = 1'b1;
            end else if (clk_fall) begin
                timeout_cnt_next = '0;
            end else begin
                timeout_cnt_next = timeout_cnt_reg + TW'(1);
            end
        end

        busy_next = (state_next != S_IDLE);
    end

    assign ps2_clk_oe  = clk_oe_reg;
    assign ps2_data_oe = data_oe_reg;
    assign busy        = busy_reg;
    assign tx_done     = done_reg;
    assign tx_error    = error_reg;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device transmitter for the PS/2 port. It sends one command byte to the attached keyboard or mouse, for example 0xF4 "enable reporting" or 0xFF "reset". The block runs the full host request sequence: clock inhibit, request-to-send, device-clocked bit shifting, and ACK check. It sits beside the existing PS/2 receiver on the same two open-collector lines, and the top level builds the inout pads from its drive-low enables.

## Interface
- INHIBIT_CYCLES, 10000: number of clk cycles ps2_clk is held low before request-to-send (100 µs at 100 MHz).
- TIMEOUT_CYCLES, 200000: maximum number of clk cycles allowed between device clock falling edges, or before the bus goes idle (2 ms).
- clk, input, 1: system clock, 100 MHz.
- reset, input, 1: asynchronous, active-high reset.
- tx_data, input, 8: command byte, latched on the accepting cycle.
- tx_start, input, 1: one-cycle request; accepted only in IDLE.
- ps2_clk_in, input, 1: raw PS/2 clock pad level.
- ps2_data_in, input, 1: raw PS/2 data pad level.
- ps2_clk_oe, output, 1: 1 pulls the clock line low; 0 releases it.
- ps2_data_oe, output, 1: 1 pulls the data line low; 0 releases it.
- busy, output, 1: high in every state except IDLE.
- tx_done, output, 1: one-cycle pulse when a transfer completes with ACK.
- tx_error, output, 1: one-cycle pulse on missing ACK or timeout.

## Operation
- Input synchronizers: ps2_clk_in and ps2_data_in each pass through 2 flops, then a third clock flop stage provides edge detection. fall = s3 & ~s2.
- Frame bits: d0..d7 (LSB first), then parity = ~^tx_data (odd), then stop = 1. ps2_data_oe = ~bit.
- IDLE: both oe outputs are 0. On tx_start, latch tx_data and the parity bit into a 10-bit shift register, clear the counters, and go to INHIBIT.
- INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles, then go to RTS.
- RTS: clk_oe=1, data_oe=1 (start bit) for exactly 1 cycle, then go to SEND.
- SEND: clk_oe=0 and data_oe stays 1.
  - Each fall shifts out the next frame bit and increments bit_cnt.
  - Falls 1–8 drive d0..d7, fall 9 drives parity, fall 10 drives the stop bit (data_oe=0).
  - After fall 10, go to ACK.
- ACK: on fall 11, sample synchronized data. If it is 0, go to WAIT_IDLE. If it is 1, go to IDLE and pulse tx_error.
- WAIT_IDLE: when synchronized clk and data are both 1, go to IDLE and pulse tx_done.
- Timeout: a counter runs in SEND, ACK and WAIT_IDLE and clears on every fall.
  - If it reaches TIMEOUT_CYCLES-1, go to IDLE, release both lines, and pulse tx_error.
  - The timeout has priority over a simultaneous fall.
- tx_start while busy is ignored. It is not queued, and the latched data is unchanged.
- tx_done and tx_error are never high together.

## Timing
- All outputs are registered. Reset values: ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_done=0, tx_error=0, state=IDLE.
- Reset asserted mid-transfer releases both lines immediately (asynchronously) and produces no done or error pulse.
- busy rises at the clk edge that accepts tx_start. ps2_clk_oe rises on that same edge.
- ps2_clk_oe is high for INHIBIT_CYCLES+1 cycles in total (INHIBIT plus RTS). ps2_data_oe rises at the last of these edges.
- Bit update latency: if ps2_clk_in is first sampled low at edge k, ps2_data_oe updates at edge k+2.
- tx_done and tx_error are asserted in the first IDLE cycle with busy=0. A new tx_start is accepted in that same cycle.
- bit_cnt is 4 bits wide and the timeout counter is $clog2(TIMEOUT_CYCLES) bits wide. Neither wraps: both are cleared on entry to INHIBIT.

## Test plan
- Send 0xF4 to a device model that clocks at 12.5 kHz and ACKs.
  - Bench checks 11 falls with sampled bits 0,0,0,1,0,1,1,1,1 on the rising edges, parity 0 and stop 1.
  - Required response: tx_done pulses once, busy goes to 0 and both oe outputs read 0.
- Send 0xFF with an ACKing device -> captured parity bit is 1 and tx_done pulses.
- Send 0x00 to a device that leaves data high at fall 11 -> tx_error pulses and tx_done stays 0. Captured parity bit is 1.
- Device stops clocking after fall 4 -> tx_error pulses exactly TIMEOUT_CYCLES cycles after fall 4 is detected, and both lines are released.
- Pulse tx_start with 0x12 during INHIBIT -> ignored. The frame still carries the original byte, and exactly one done pulse follows.
- Assert reset during SEND after fall 5 -> ps2_clk_oe and ps2_data_oe read 0 before the next clk edge. There is no done or error pulse, and a following 0xF4 transfer completes normally.
